// File: rtl/bool3_pipe_pkg.sv
// bool3_pkg: op encoding and per-bit evaluation shared by the bool3_pipe datapath.
package bool3_pkg;

    typedef enum logic [1:0] {
        OP_AO   = 2'd0,
        OP_XOR3 = 2'd1,
        OP_MAJ  = 2'd2,
        OP_AND3 = 2'd3
    } op_e;

    function automatic logic bool3_eval(input op_e op, input logic a, input logic b, input logic c);
        return (op == OP_AO)   ? ((a & b) | c) :
               (op == OP_XOR3) ? (a ^ b ^ c) :
               (op == OP_MAJ)  ? ((a & b) | (a & c) | (b & c)) :
                                 (a & b & c);
    endfunction

endpackage

// File: rtl/bool3_pipe_stage.sv
// bool3_stage: one elastic register stage; loads whenever it is empty or downstream advances.
module bool3_stage
    import bool3_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv_i,
    input  logic          vld_i,
    input  op_e           op_i,
    input  logic [DW-1:0] data_i,
    output logic          adv_o,
    output logic          vld_o,
    output op_e           op_o,
    output logic [DW-1:0] data_o
);

    logic          vld_q, vld_d;
    op_e           op_q, op_d;
    logic [DW-1:0] data_q, data_d;

    assign adv_o = !vld_q | adv_i;

    always_comb begin
        vld_d  = adv_o ? vld_i  : vld_q;
        op_d   = adv_o ? op_i   : op_q;
        data_d = adv_o ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            op_q   <= OP_AO;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            op_q   <= op_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign op_o   = op_q;
    assign data_o = data_q;

endmodule

// File: rtl/bool3_pipe.sv
// bool3_pipe: pipelined 3-input bitwise boolean unit with valid/ready flow control.
// Define BOOL3_PIPE_PARITY_EN to add y_par, the XOR-reduce of y carried with each beat.
module bool3_pipe
    import bool3_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       out_op
`ifdef BOOL3_PIPE_PARITY_EN
    ,
    output logic             y_par
`endif
);

`ifdef BOOL3_PIPE_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int DW = WIDTH + PAR_W;

    logic [WIDTH-1:0] res;
    logic [STAGES:0]  adv_s;
    logic [STAGES:0]  vld_s;
    op_e              op_s   [STAGES+1];
    logic [DW-1:0]    data_s [STAGES+1];

    always_comb begin
        res = '0;
        for (int i = 0; i < WIDTH; i++) res[i] = bool3_eval(op_e'(op), a[i], b[i], c[i]);
    end

    // Index 0 is the input port; index k+1 is the output of stage k.
    assign adv_s[STAGES] = out_ready;
    assign vld_s[0]      = in_valid;
    assign op_s[0]       = op_e'(op);
`ifdef BOOL3_PIPE_PARITY_EN
    assign data_s[0]     = {^res, res};
`else
    assign data_s[0]     = res;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        bool3_stage #(.DW(DW)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv_i  (adv_s[k+1]),
            .vld_i  (vld_s[k]),
            .op_i   (op_s[k]),
            .data_i (data_s[k]),
            .adv_o  (adv_s[k]),
            .vld_o  (vld_s[k+1]),
            .op_o   (op_s[k+1]),
            .data_o (data_s[k+1])
        );
    end

    assign in_ready  = adv_s[0];
    assign out_valid = vld_s[STAGES];
    assign y         = out_valid ? data_s[STAGES][WIDTH-1:0] : '0;
    assign out_op    = out_valid ? op_s[STAGES] : OP_AO;
`ifdef BOOL3_PIPE_PARITY_EN
    assign y_par     = out_valid & data_s[STAGES][DW-1];
`endif

endmodule

// File: tb/tb_bool3_pipe.sv
// tb_bool3_pipe: scoreboard bench for bool3_pipe (WIDTH=8, STAGES=2), directed plus random traffic.
module tb_bool3_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       op = 2'd0;
    logic [WIDTH-1:0] a = '0, b = '0, c = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] y;
    logic [1:0]       out_op;
`ifdef BOOL3_PIPE_PARITY_EN
    logic             y_par;
`endif

    bool3_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_op    (out_op)
`ifdef BOOL3_PIPE_PARITY_EN
        ,
        .y_par     (y_par)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] y;
        logic             par;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t q[$];
    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   accepted = 0;
    bit   lat_en = 1'b0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-bit reference: count the ones among a,b,c and apply each function's rule.
    function automatic logic [WIDTH-1:0] model(input logic [1:0] o, input logic [WIDTH-1:0] x1,
                                               input logic [WIDTH-1:0] x2, input logic [WIDTH-1:0] x3);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            int n;
            n = int'(x1[i]) + int'(x2[i]) + int'(x3[i]);
            case (o)
                2'd0:    r[i] = x3[i] || (x1[i] && x2[i]);
                2'd1:    r[i] = (n % 2) == 1;
                2'd2:    r[i] = n >= 2;
                default: r[i] = n == 3;
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [1:0] o, input logic [WIDTH-1:0] x1,
                        input logic [WIDTH-1:0] x2, input logic [WIDTH-1:0] x3);
        exp_t e;
        @(posedge clk) #1;
        in_valid = 1'b1; op = o; a = x1; b = x2; c = x3;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (in_ready) break;
            if (n > 1000) begin
                asserts++; fails++;
                $display("FAIL send_timeout: in_ready stuck at 0, required 1");
                return;
            end
        end
        e.op = o; e.y = model(o, x1, x2, x3); e.par = ^e.y; e.cyc = cyc; e.lat = lat_en;
        q.push_back(e);
        accepted++;
    endtask

    task automatic idle();
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    logic             stall = 1'b0;
    logic [WIDTH-1:0] prev_y;
    logic [1:0]       prev_op;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_y", y, prev_y);
                chk("stall_op", out_op, prev_op);
            end
            if (!out_valid) begin
                chk("idle_y", y, '0);
            end else if (out_ready) begin
                if (q.size() == 0) begin
                    asserts++; fails++;
                    $display("FAIL unexpected_beat: got y=%0h op=%0d, required no beat", y, out_op);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("y", y, e.y);
                    chk("out_op", out_op, e.op);
`ifdef BOOL3_PIPE_PARITY_EN
                    chk("y_par", y_par, e.par);
`endif
                    if (e.lat) chk("latency", cyc - e.cyc, STAGES);
                end
            end
            stall = out_valid && !out_ready;
            prev_y = y;
            prev_op = out_op;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, '0);
        chk("rst_out_op", out_op, 2'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        lat_en = 1'b1;
        send(2'd0, 8'hFF, 8'hFF, 8'hFF);
        send(2'd0, 8'hFF, 8'hFF, 8'h00);
        send(2'd0, 8'hF0, 8'h3C, 8'h00);
        idle();
        repeat (4) @(posedge clk);
        for (int o = 0; o < 4; o++) send(o[1:0], 8'hAA, 8'hCC, 8'hF0);
        send(2'd1, 8'h01, 8'h00, 8'h00);
        idle();
        repeat (4) @(posedge clk);
        lat_en = 1'b0;

        @(posedge clk) #1;
        out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(2'(i), 8'(i * 37 + 5), 8'(i * 91 + 3), 8'(i * 11));
                idle();
            end
        join_none
        repeat (6) @(negedge clk);
        chk("bp_accepted", accepted, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        @(posedge clk) #1;
        out_ready = 1'b1;
        wait fork;
        repeat (6) @(posedge clk);
        chk("bp_drained", q.size(), 0);

        @(posedge clk) #1;
        out_ready = 1'b0;
        send(2'd2, 8'h5A, 8'hA5, 8'hFF);
        send(2'd3, 8'hFF, 8'h0F, 8'h3C);
        idle();
        @(posedge clk) #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_y", y, '0);
        q.delete();
        @(posedge clk) #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        repeat (6) @(posedge clk);

        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(3) == 0) begin
                        idle();
                        repeat ($urandom_range(2)) @(posedge clk);
                    end
                    send(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 8'($urandom));
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk) #1;
                    out_ready = $urandom_range(3) != 0;
                end
            end
        join
        @(posedge clk) #1;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk("final_drained", q.size(), 0);
        chk("final_out_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
